// File: rtl/usart_pkg.sv
// Shared encodings for the configurable UART receiver family.
// Holds the parity-mode encodings and the receive FSM state type.
// No ports; imported by usart_bit_sampler and usart_rx_cfg.
package usart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_DONE   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/usart_bit_sampler.sv
// Oversampling front end: 2-FF synchroniser, falling-edge detect, per-bit majority vote.
// Ports: clkb/rst_n; rx_i raw pin; en_i runs the bit counter (cleared when low);
//        rxs_o synchronised line, fall_o start-edge strobe, bit_tick_o/bit_val_o bit decision.
module usart_bit_sampler
  import usart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic clkb,
  input  logic rst_n,
  input  logic rx_i,
  input  logic en_i,
  output logic rxs_o,
  output logic fall_o,
  output logic bit_tick_o,
  output logic bit_val_o
);

  localparam int CW = $clog2(OVS);
  localparam int OW = $clog2(OVS + 1);

  logic          sync_q;
  logic          rxs_q;
  logic          rxs_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [OW-1:0] ones_inc;

  // The current sample is folded in, so the vote covers all OVS samples of the period.
  assign ones_inc  = ones_q + OW'(rxs_q);
  assign bit_val_o = (ones_inc > OW'(OVS / 2));
  assign fall_o    = rxs_dly_q & ~rxs_q;
  assign rxs_o     = rxs_q;

  always_comb begin
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    bit_tick_o = 1'b0;
    if (!en_i) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (cnt_q == CW'(OVS - 1)) begin
      bit_tick_o = 1'b1;
      cnt_d      = '0;
      ones_d     = '0;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      ones_d = ones_inc;
    end
  end

  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      sync_q    <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
      cnt_q     <= '0;
      ones_q    <= '0;
    end else begin
      sync_q    <= rx_i;
      rxs_q     <= sync_q;
      rxs_dly_q <= rxs_q;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
    end
  end

endmodule

// File: rtl/usart_rx_cfg.sv
// Configurable oversampling UART receiver with a one-entry valid/ready holding register.
// Ports: clkb/rst_n; rx serial in; rx_ready consumer accept; rx_busy frame in progress;
//        rx_valid/rx_data/rx_perr/rx_ferr held word; rx_ovr one-cycle dropped-frame pulse.
module usart_rx_cfg
  import usart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clkb,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovr
);

  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(OVS + 1);

  rx_state_e            state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 armed_q, armed_d;
  logic [AW-1:0]        arm_cnt_q, arm_cnt_d;

  logic rxs, fall, bit_tick, bit_val;
  logic start_go, in_frame, par_odd;

  assign par_odd  = (PARITY == PAR_ODD);
  assign in_frame = (state_q == RX_START) || (state_q == RX_DATA) ||
                    (state_q == RX_PARITY) || (state_q == RX_STOP);
  // A start edge is honoured in IDLE, and in DONE unless this frame is about to disarm us.
  assign start_go = fall & armed_q &
                    ((state_q == RX_IDLE) || ((state_q == RX_DONE) && !ferr_acc_q));

  // Counting begins in the edge cycle itself so the last stop period ends one cycle
  // before the next frame's start edge can arrive, letting DONE catch it.
  usart_bit_sampler #(.OVS(OVS)) u_sampler (
    .clkb       (clkb),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .en_i       (in_frame | start_go),
    .rxs_o      (rxs),
    .fall_o     (fall),
    .bit_tick_o (bit_tick),
    .bit_val_o  (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    idx_d      = idx_q;
    armed_d    = armed_q;
    arm_cnt_d  = arm_cnt_q;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    // Re-arm only after a clean full bit period of idle line following a framing error.
    if (!armed_q) begin
      if (!rxs) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == AW'(OVS - 1)) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + AW'(1);
      end
    end

    case (state_q)
      RX_IDLE: begin
        if (start_go) begin
          state_d    = RX_START;
          idx_d      = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      RX_START: begin
        if (bit_tick) begin
          state_d = bit_val ? RX_IDLE : RX_DATA;
          idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          shift_d[idx_q] = bit_val;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (bit_tick) begin
          perr_acc_d = bit_val ^ (^shift_q) ^ par_odd;
          idx_d      = '0;
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          ferr_acc_d = ferr_acc_q | ~bit_val;
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = RX_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      RX_DONE: begin
        if (!valid_q || rx_ready) begin
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = perr_acc_q;
          ferr_d  = ferr_acc_q;
        end else begin
          ovr_d = 1'b1;
        end
        if (ferr_acc_q) begin
          armed_d   = 1'b0;
          arm_cnt_d = '0;
        end
        if (start_go) begin
          state_d    = RX_START;
          idx_d      = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      idx_q      <= '0;
      armed_q    <= 1'b1;
      arm_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      idx_q      <= idx_d;
      armed_q    <= armed_d;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

  assign rx_busy  = busy_q;
  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign rx_perr  = perr_q;
  assign rx_ferr  = ferr_q;
  assign rx_ovr   = ovr_q;

endmodule

// File: tb/tb_usart_rx_cfg.sv
// Bench for usart_rx_cfg: three configurations (8N1, 8E1, 7N2) driven by directed frames.
// Expected words are queued when a frame is sent; a monitor pops on every handshake.
module tb_usart_rx_cfg;

  localparam int OVS = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] rx_v;
  logic [2:0] rdy_v;
  logic [2:0] busy_v, valid_v, perr_v, ferr_v, ovr_v;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [8:0] data_w [3];

  int   vecs;
  int   fails;
  int   ovr_cnt [3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  assign data_w[0] = {1'b0, data_a};
  assign data_w[1] = {1'b0, data_b};
  assign data_w[2] = {2'b00, data_c};

  usart_rx_cfg #(.DATA_BITS(8), .OVS(OVS), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clkb(clk), .rst_n(rst_n), .rx(rx_v[0]), .rx_ready(rdy_v[0]),
    .rx_busy(busy_v[0]), .rx_valid(valid_v[0]), .rx_data(data_a),
    .rx_perr(perr_v[0]), .rx_ferr(ferr_v[0]), .rx_ovr(ovr_v[0]));

  usart_rx_cfg #(.DATA_BITS(8), .OVS(OVS), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clkb(clk), .rst_n(rst_n), .rx(rx_v[1]), .rx_ready(rdy_v[1]),
    .rx_busy(busy_v[1]), .rx_valid(valid_v[1]), .rx_data(data_b),
    .rx_perr(perr_v[1]), .rx_ferr(ferr_v[1]), .rx_ovr(ovr_v[1]));

  usart_rx_cfg #(.DATA_BITS(7), .OVS(OVS), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clkb(clk), .rst_n(rst_n), .rx(rx_v[2]), .rx_ready(rdy_v[2]),
    .rx_busy(busy_v[2]), .rx_valid(valid_v[2]), .rx_data(data_c),
    .rx_perr(perr_v[2]), .rx_ferr(ferr_v[2]), .rx_ovr(ovr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    vecs++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input int i, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check_pop(input int i, input exp_t got);
    exp_t e;
    int   sz;
    sz = qsize(i);
    chk($sformatf("word_expected_%0d", i), int'(sz > 0), 1);
    if (sz > 0) begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("rx_data_%0d", i), int'(got.d), int'(e.d));
      chk($sformatf("rx_perr_%0d", i), int'(got.pe), int'(e.pe));
      chk($sformatf("rx_ferr_%0d", i), int'(got.fe), int'(e.fe));
    end
  endtask

  // Monitor: every accepted word is compared against the head of its queue.
  always @(negedge clk) begin
    exp_t g;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && valid_v[i] && rdy_v[i]) begin
        g.d  = data_w[i];
        g.pe = perr_v[i];
        g.fe = ferr_v[i];
        check_pop(i, g);
      end
      if (ovr_v[i]) ovr_cnt[i]++;
    end
  end

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int i, input logic b, input bit noisy);
    for (int c = 0; c < OVS; c++) begin
      rx_v[i] = (noisy && c == 8) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  // pbit < 0 means no parity bit on the wire.
  task automatic send_frame(input int i, input logic [8:0] d, input int nb, input int pbit,
                            input int nstop, input logic stopv, input bit noisy);
    logic [8:0] dv;
    dv = d;
    drive_bit(i, 1'b0, noisy);
    for (int k = 0; k < nb; k++) drive_bit(i, dv[k], noisy);
    if (pbit >= 0) drive_bit(i, pbit[0], noisy);
    for (int k = 0; k < nstop; k++) drive_bit(i, stopv, noisy);
    rx_v[i] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs  = 0;
    fails = 0;
    for (int i = 0; i < 3; i++) ovr_cnt[i] = 0;
    rst_n = 1'b0;
    rx_v  = 3'b111;
    rdy_v = 3'b111;
    cycles(5);
    rst_n = 1'b1;
    cycles(2);

    // Reset state
    chk("reset_valid", int'(valid_v), 0);
    chk("reset_busy",  int'(busy_v), 0);
    chk("reset_ovr",   int'(ovr_v), 0);
    chk("reset_flags", int'({perr_v, ferr_v}), 0);
    chk("reset_data_a", int'(data_a), 0);

    // 8N1 byte 0xA5
    push_exp(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 1'b0);
    cycles(20);
    chk("a5_popped", qsize(0), 0);
    chk("a5_valid_one_cycle", int'(valid_v[0]), 0);
    chk("a5_busy_idle", int'(busy_v[0]), 0);

    // Even parity: 0x03 with wrong parity bit, then correct one
    push_exp(1, 9'h003, 1'b1, 1'b0);
    send_frame(1, 9'h003, 8, 1, 1, 1'b1, 1'b0);
    cycles(20);
    push_exp(1, 9'h003, 1'b0, 1'b0);
    send_frame(1, 9'h003, 8, 0, 1, 1'b1, 1'b0);
    cycles(20);
    chk("parity_popped", qsize(1), 0);

    // Start glitch: 5 low samples, then next frame 0x5A
    rx_v[0] = 1'b0;
    cycles(5);
    chk("glitch_busy_high", int'(busy_v[0]), 1);
    rx_v[0] = 1'b1;
    cycles(30);
    chk("glitch_busy_low", int'(busy_v[0]), 0);
    chk("glitch_no_valid", int'(valid_v[0]), 0);
    push_exp(0, 9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1, 1'b0);
    cycles(20);
    chk("glitch_next_popped", qsize(0), 0);

    // Overrun: consumer stalled, second frame dropped
    rdy_v[0] = 1'b0;
    push_exp(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, -1, 1, 1'b1, 1'b0);
    cycles(20);
    chk("ovr_first_valid", int'(valid_v[0]), 1);
    chk("ovr_first_data", int'(data_a), 'h11);
    send_frame(0, 9'h022, 8, -1, 1, 1'b1, 1'b0);
    cycles(20);
    chk("ovr_pulses", ovr_cnt[0], 1);
    chk("ovr_held_data", int'(data_a), 'h11);
    chk("ovr_held_valid", int'(valid_v[0]), 1);
    rdy_v[0] = 1'b1;
    cycles(5);
    chk("ovr_drained", qsize(0), 0);
    chk("ovr_after_read_valid", int'(valid_v[0]), 0);

    // Line held low for three frame times: exactly one word 0x00 with ferr
    push_exp(0, 9'h000, 1'b0, 1'b1);
    rx_v[0] = 1'b0;
    cycles(3 * 10 * OVS);
    rx_v[0] = 1'b1;
    cycles(40);
    chk("break_one_word", qsize(0), 0);
    chk("break_busy", int'(busy_v[0]), 0);
    chk("break_no_ovr", ovr_cnt[0], 1);
    push_exp(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1, 1'b0);
    cycles(20);
    chk("break_next_popped", qsize(0), 0);

    // 7N2 with one noisy sample per bit
    push_exp(2, 9'h07F, 1'b0, 1'b0);
    send_frame(2, 9'h07F, 7, -1, 2, 1'b1, 1'b1);
    cycles(20);
    chk("noisy_popped", qsize(2), 0);

    // Reset in the middle of DATA: frame aborted
    drive_bit(2, 1'b0, 1'b0);
    drive_bit(2, 1'b1, 1'b0);
    drive_bit(2, 1'b0, 1'b0);
    drive_bit(2, 1'b1, 1'b0);
    chk("midreset_busy_before", int'(busy_v[2]), 1);
    rst_n   = 1'b0;
    rx_v[2] = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    chk("midreset_busy_after", int'(busy_v[2]), 0);
    cycles(200);
    chk("midreset_no_valid", int'(valid_v[2]), 0);
    chk("midreset_busy_quiet", int'(busy_v[2]), 0);
    push_exp(2, 9'h015, 1'b0, 1'b0);
    send_frame(2, 9'h015, 7, -1, 2, 1'b1, 1'b0);
    cycles(20);

    chk("final_q0", qsize(0), 0);
    chk("final_q1", qsize(1), 0);
    chk("final_q2", qsize(2), 0);
    chk("final_ovr_b", ovr_cnt[1], 0);
    chk("final_ovr_c", ovr_cnt[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
